// File: rtl/long_sub_core.sv
// Pipelined wide unsigned subtractor with a registered Kogge-Stone borrow network
// and a valid/ready stream interface; all stages freeze together under backpressure.
module long_sub_core #(
  parameter int SIZE       = 1024,
  parameter int ADDER_SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] din_a,
  input  logic [SIZE-1:0] din_b,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] dout,
  output logic            borrow_out,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int ADDER_NUM = SIZE / ADDER_SIZE;
  localparam int LEVELS    = $clog2(ADDER_NUM);

  logic                  stall;
  logic [LEVELS:0]       vld_p;
  logic [ADDER_SIZE-1:0] d_p [0:LEVELS][0:ADDER_NUM-1];
  logic [ADDER_NUM-1:0]  g_p [0:LEVELS];
  logic [ADDER_NUM-1:0]  p_p [0:LEVELS];
  logic [ADDER_NUM-1:0]  bin_vec;
  logic [SIZE-1:0]       dout_nxt;

  // Segment subtraction; the extra MSB is the local borrow.
  function automatic logic [ADDER_SIZE:0] seg_sub(input logic [ADDER_SIZE-1:0] a,
                                                  input logic [ADDER_SIZE-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  function automatic logic [ADDER_SIZE-1:0] seg_dec(input logic [ADDER_SIZE-1:0] d,
                                                    input logic                  bin);
    return d - {{(ADDER_SIZE-1){1'b0}}, bin};
  endfunction

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (!stall) begin
      vld_p <= {vld_p[LEVELS-1:0], in_valid};
    end
  end

  // Stage p0: per-segment difference, generate and propagate.
  // Stages p1..pLEVELS: one prefix level each; low segments pass through because the
  // shifted-in G bits are zero and the low P bits are masked to one.
  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int i = 0; i < ADDER_NUM; i++) begin
        {g_p[0][i], d_p[0][i]} <= seg_sub(din_a[i*ADDER_SIZE +: ADDER_SIZE],
                                          din_b[i*ADDER_SIZE +: ADDER_SIZE]);
        p_p[0][i] <= (din_a[i*ADDER_SIZE +: ADDER_SIZE] == din_b[i*ADDER_SIZE +: ADDER_SIZE]);
      end
      for (int k = 1; k <= LEVELS; k++) begin
        g_p[k] <= g_p[k-1] | (p_p[k-1] & (g_p[k-1] << (1 << (k-1))));
        p_p[k] <= p_p[k-1] & ((p_p[k-1] << (1 << (k-1))) |
                              ~({ADDER_NUM{1'b1}} << (1 << (k-1))));
        for (int j = 0; j < ADDER_NUM; j++) begin
          d_p[k][j] <= d_p[k-1][j];
        end
      end
    end
  end

  // Final stage: apply the resolved borrow entering each segment.
  assign bin_vec = {g_p[LEVELS][ADDER_NUM-2:0], 1'b0};

  always_comb begin
    dout_nxt = '0;
    for (int i = 0; i < ADDER_NUM; i++) begin
      dout_nxt[i*ADDER_SIZE +: ADDER_SIZE] = seg_dec(d_p[LEVELS][i], bin_vec[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      borrow_out <= 1'b0;
      out_valid  <= 1'b0;
    end else if (!stall) begin
      dout       <= dout_nxt;
      borrow_out <= g_p[LEVELS][ADDER_NUM-1];
      out_valid  <= vld_p[LEVELS];
    end
  end

endmodule

// File: tb/tb_long_sub_core.sv
// Directed-vector and streaming bench for long_sub_core at SIZE=32, ADDER_SIZE=8.
module tb_long_sub_core;

  localparam int SIZE       = 32;
  localparam int ADDER_SIZE = 8;
  localparam int LATENCY    = 4;
  localparam int NRAND      = 10000;

  logic            clk;
  logic            rst_n;
  logic [SIZE-1:0] din_a;
  logic [SIZE-1:0] din_b;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] dout;
  logic            borrow_out;
  logic            out_valid;
  logic            out_ready;

  long_sub_core #(.SIZE(SIZE), .ADDER_SIZE(ADDER_SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .din_a(din_a), .din_b(din_b),
    .in_valid(in_valid), .in_ready(in_ready), .dout(dout),
    .borrow_out(borrow_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        bo;
  } vec_t;

  vec_t        vecs [11];
  int          checks;
  int          failures;
  logic [32:0] exp_q [$];
  logic [32:0] exp_v;

  int   pi, ri, hold, first_fire, last_fire;
  bit   dropped, fin, fout, seen_valid, prev_stall;
  int   sent, recv, bubble, stale, rdy_cyc;
  logic [31:0] prev_dout;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
    end
  endtask

  // Called at posedge+1 with out_ready=1; checks the result lands exactly at LATENCY.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic bo, input string tag);
    din_a    = a;
    din_b    = b;
    in_valid = 1'b1;
    for (int c = 1; c <= LATENCY; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (c < LATENCY) chk({tag, " early out_valid"}, 64'(out_valid), 64'd0);
    end
    chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, " dout"}, 64'(dout), 64'(d));
    chk({tag, " borrow_out"}, 64'(borrow_out), 64'(bo));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0]  = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1};
    vecs[1]  = '{32'h01000000, 32'h00000001, 32'h00FFFFFF, 1'b0};
    vecs[2]  = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[3]  = '{32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0};
    vecs[4]  = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[5]  = '{32'h00000000, 32'hFFFFFFFF, 32'h00000001, 1'b1};
    vecs[6]  = '{32'h12345678, 32'h11111111, 32'h01234567, 1'b0};
    vecs[7]  = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 1'b1};
    vecs[8]  = '{32'hFF00FF00, 32'h00FF00FF, 32'hFE01FE01, 1'b0};
    vecs[9]  = '{32'h00010000, 32'h00000100, 32'h0000FF00, 1'b0};
    vecs[10] = '{32'h00000100, 32'h00000101, 32'hFFFFFFFF, 1'b1};

    // Reset
    rst_n     = 1'b1;
    din_a     = '0;
    din_b     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset dout", 64'(dout), 64'd0);
    chk("reset borrow_out", 64'(borrow_out), 64'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset in_ready", 64'(in_ready), 64'd1);
    chk("post-reset out_valid", 64'(out_valid), 64'd0);

    // Directed vectors
    for (int v = 0; v < 11; v++) begin
      run_one(vecs[v].a, vecs[v].b, vecs[v].d, vecs[v].bo, $sformatf("vec%0d", v));
    end

    // Backpressure: pairs (k,1), k=10..15, stall 5 cycles at first result
    idle(1);
    pi = 0; ri = 0; hold = 0; first_fire = -1; last_fire = -1; dropped = 1'b0;
    din_a = 32'd10; din_b = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && ri < 6; cyc++) begin
      if (!dropped && out_valid) begin
        out_ready = 1'b0; dropped = 1'b1; hold = 5;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) out_ready = 1'b1;
      end
      @(negedge clk);
      fin  = in_valid & in_ready;
      fout = out_valid & out_ready;
      if (!out_ready) begin
        chk("bp in_ready", 64'(in_ready), 64'd0);
        chk("bp held dout", 64'(dout), 64'd9);
        chk("bp held out_valid", 64'(out_valid), 64'd1);
      end
      if (fout) begin
        chk("bp order", 64'(dout), 64'(9 + ri));
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
        ri++;
      end
      @(posedge clk); #1;
      if (fin) begin
        pi++;
        din_a    = 32'(10 + pi);
        in_valid = (pi < 6);
      end
    end
    chk("bp stalled", 64'(dropped), 64'd1);
    chk("bp result count", 64'(ri), 64'd6);
    chk("bp burst span", 64'(last_fire - first_fire), 64'd5);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp no duplicate", 64'(out_valid), 64'd0);
    end

    // Reset mid-stream with 4 pairs in flight
    for (int i = 0; i < 4; i++) begin
      din_a = 32'(100 + i); din_b = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mid pre-reset out_valid", 64'(out_valid), 64'd1);
    chk("mid pre-reset dout", 64'(dout), 64'd99);
    #3 rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", 64'(out_valid), 64'd0);
    chk("mid reset dout", 64'(dout), 64'd0);
    chk("mid reset in_ready", 64'(in_ready), 64'd1);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("mid no stale result", 64'(out_valid), 64'd0);
    end
    run_one(32'd5, 32'd3, 32'd2, 1'b0, "mid first new");

    // Random back-to-back stream with 70% out_ready
    idle(1);
    sent = 0; recv = 0; bubble = 0; stale = 0; rdy_cyc = 0;
    seen_valid = 1'b0; prev_stall = 1'b0; prev_dout = '0;
    din_a = $urandom; din_b = $urandom; in_valid = 1'b1;
    for (int cyc = 0; cyc < 40000 && recv < NRAND; cyc++) begin
      out_ready = ($urandom_range(99) < 70);
      @(negedge clk);
      fin  = in_valid & in_ready;
      fout = out_valid & out_ready;
      if (prev_stall && dout !== prev_dout) stale++;
      if (out_valid) seen_valid = 1'b1;
      if (seen_valid && sent < NRAND && !out_valid) bubble++;
      if (seen_valid && out_ready) rdy_cyc++;
      if (fout) begin
        if (exp_q.size() == 0) begin
          chk("rand unexpected result", 64'(dout), 64'd0);
          chk("rand queue underflow", 64'd1, 64'd0);
        end else begin
          exp_v = exp_q.pop_front();
          chk("rand result", 64'({borrow_out, dout}), 64'(exp_v));
        end
        recv++;
      end
      if (fin) begin
        exp_q.push_back({(din_a < din_b), din_a - din_b});
        sent++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_dout  = dout;
      @(posedge clk); #1;
      if (fin) begin
        if (sent < NRAND) begin
          din_a = $urandom;
          if ($urandom_range(3) == 0) din_b = din_a + 32'($urandom_range(1));
          else din_b = $urandom;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("rand received", 64'(recv), 64'(NRAND));
    chk("rand leftover", 64'(exp_q.size()), 64'd0);
    chk("rand bubbles", 64'(bubble), 64'd0);
    chk("rand stall stability", 64'(stale), 64'd0);
    chk("rand throughput", 64'(rdy_cyc), 64'(recv));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
